// File: rtl/fp_unpack_norm_if.sv
// Operand/result bundle between the format lookup, the unpacker and the divsqrt/convert datapath.
interface fp_unpack_norm_if #(
    parameter int FLEN    = 64,
    parameter int NE      = 11,
    parameter int NF      = 52,
    parameter int LOGFLEN = 6
);
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [FLEN-1:0]    x;
    logic [NE-2:0]      bias;
    logic [LOGFLEN-1:0] nf;
    logic               out_valid;
    logic               out_ready;
    logic               sgn;
    logic [NE+1:0]      exp;
    logic [NF:0]        mant;
    logic               zero;
    logic               inf;
    logic               nan;
    logic               subn;

    modport master (
        output flush, in_valid, x, bias, nf, out_ready,
        input  in_ready, out_valid, sgn, exp, mant, zero, inf, nan, subn
    );

    modport slave (
        input  flush, in_valid, x, bias, nf, out_ready,
        output in_ready, out_valid, sgn, exp, mant, zero, inf, nan, subn
    );
endinterface

// File: rtl/fp_unpack_norm.sv
// FP operand unpacker: splits sign/exponent/significand, normalizes subnormals one bit per cycle.
// Latency 1 cycle (1+k for subnormals); result held in DONE until out_ready, no capture meanwhile.
module fp_unpack_norm #(
    parameter int FLEN    = 64,
    parameter int NE      = 11,
    parameter int NF      = 52,
    parameter int LOGFLEN = 6
) (
    input  logic         clk,
    input  logic         reset,
    fp_unpack_norm_if.slave io
);
    localparam int EW = NE + 2;
    localparam int SW = NE + 1;

    typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

    state_t state, state_nxt;

    logic [NE-1:0] exp_mask;
    logic [SW-1:0] sgn_mask;
    logic [NE-1:0] dec_e;
    logic [NF-1:0] dec_frac;
    logic [NF-1:0] dec_fraca;
    logic          dec_sgn;
    logic          dec_zero, dec_inf, dec_nan, dec_subn;
    logic [NF:0]   dec_mant;
    logic [EW-1:0] dec_exp;

    logic          sgn_q;
    logic [EW-1:0] exp_q;
    logic [NF:0]   mant_q;
    logic          zero_q, inf_q, nan_q, subn_q;

    // Exponent field width is implied by the bias, so the sign sits one bit above the mask.
    always_comb begin
        exp_mask  = {io.bias, 1'b1};
        sgn_mask  = {1'b0, exp_mask} + SW'(1);
        dec_e     = NE'(io.x >> io.nf) & exp_mask;
        dec_sgn   = |(SW'(io.x >> io.nf) & sgn_mask);
        dec_frac  = NF'(io.x & ~({FLEN{1'b1}} << io.nf));
        dec_fraca = dec_frac << (LOGFLEN'(NF) - io.nf);

        dec_zero  = 1'b0;
        dec_inf   = 1'b0;
        dec_nan   = 1'b0;
        dec_subn  = 1'b0;
        dec_mant  = {1'b1, dec_fraca};
        dec_exp   = EW'(dec_e) - EW'(io.bias);

        if (dec_e == exp_mask) begin
            dec_inf = (dec_frac == '0);
            dec_nan = (dec_frac != '0);
        end else if (dec_e == '0) begin
            if (dec_frac == '0) begin
                dec_zero = 1'b1;
                dec_mant = '0;
                dec_exp  = '0;
            end else begin
                dec_subn = 1'b1;
                dec_mant = {1'b0, dec_fraca};
                dec_exp  = EW'(1) - EW'(io.bias);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NORM exits when the bit about to shift into the leading position is set.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (io.in_valid) state_nxt = dec_subn ? NORM : DONE;
            NORM: if (mant_q[NF-1]) state_nxt = DONE;
            DONE: if (io.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (io.flush) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sgn_q  <= 1'b0;
            exp_q  <= '0;
            mant_q <= '0;
            zero_q <= 1'b0;
            inf_q  <= 1'b0;
            nan_q  <= 1'b0;
            subn_q <= 1'b0;
        end else if (!io.flush) begin
            if (state == IDLE && io.in_valid) begin
                sgn_q  <= dec_sgn;
                exp_q  <= dec_exp;
                mant_q <= dec_mant;
                zero_q <= dec_zero;
                inf_q  <= dec_inf;
                nan_q  <= dec_nan;
                subn_q <= dec_subn;
            end else if (state == NORM) begin
                mant_q <= mant_q << 1;
                exp_q  <= exp_q - EW'(1);
            end
        end
    end

    assign io.in_ready  = (state == IDLE);
    assign io.out_valid = (state == DONE);
    assign io.sgn       = sgn_q;
    assign io.exp       = exp_q;
    assign io.mant      = mant_q;
    assign io.zero      = zero_q;
    assign io.inf       = inf_q;
    assign io.nan       = nan_q;
    assign io.subn      = subn_q;
endmodule

// File: tb/tb_fp_unpack_norm.sv
// Randomized bench for fp_unpack_norm with an integer-arithmetic reference model.
module tb_fp_unpack_norm;
    typedef struct packed {
        logic        sgn;
        logic [12:0] exp;
        logic [52:0] mant;
        logic [3:0]  flags;   // {zero, inf, nan, subn}
    } res_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;

    fp_unpack_norm_if #(.FLEN(64), .NE(11), .NF(52), .LOGFLEN(6)) io ();

    fp_unpack_norm #(.FLEN(64), .NE(11), .NF(52), .LOGFLEN(6)) dut (
        .clk  (clk),
        .reset(reset),
        .io   (io)
    );

    always #5 clk = ~clk;

    function automatic res_t cur_res();
        res_t r;
        r.sgn   = io.sgn;
        r.exp   = io.exp;
        r.mant  = io.mant;
        r.flags = {io.zero, io.inf, io.nan, io.subn};
        return r;
    endfunction

    function automatic res_t model(input logic [63:0] x, input int bias, input int nf, output int lat);
        res_t        r;
        int          nef;
        int          p;
        longint      ex;
        logic [63:0] emax, e, frac, fa;
        nef  = $clog2(bias + 1) + 1;
        emax = (64'd1 << nef) - 64'd1;
        e    = (x >> nf) & emax;
        frac = x & ((64'd1 << nf) - 64'd1);
        fa   = frac << (52 - nf);
        r    = '0;
        r.sgn = x[nf + nef];
        lat  = 1;
        ex   = 0;
        if (e == emax) begin
            r.flags = (frac == 0) ? 4'b0100 : 4'b0010;
            r.mant  = 53'((64'd1 << 52) | fa);
            ex      = longint'(e) - bias;
        end else if (e == 0 && frac == 0) begin
            r.flags = 4'b1000;
        end else if (e == 0) begin
            p = 0;
            for (int i = 0; i < 64; i++) if (frac[i]) p = i;
            r.flags = 4'b0001;
            r.mant  = 53'(frac << (52 - p));
            ex      = 1 - bias - (nf - p);
            lat     = 1 + nf - p;
        end else begin
            r.mant = 53'((64'd1 << 52) | fa);
            ex     = longint'(e) - bias;
        end
        r.exp = 13'(ex);
        return r;
    endfunction

    task automatic gen_op(output logic [63:0] x, output int bias, output int nf);
        int          nef, cls, w;
        logic [63:0] emax, e, frac, junk;
        case ($urandom_range(0, 2))
            0:       begin bias = 15;   nf = 10; end
            1:       begin bias = 127;  nf = 23; end
            default: begin bias = 1023; nf = 52; end
        endcase
        nef  = $clog2(bias + 1) + 1;
        emax = (64'd1 << nef) - 64'd1;
        cls  = $urandom_range(0, 4);
        if (cls == 0)      e = 0;
        else if (cls == 1) e = emax;
        else               e = 64'($urandom_range(1, 32'(emax) - 1));
        case ($urandom_range(0, 3))
            0:       frac = 0;
            1:       frac = 64'd1 << $urandom_range(0, nf - 1);
            default: frac = {$urandom, $urandom} & ((64'd1 << nf) - 64'd1);
        endcase
        x = frac | (e << nf) | (64'($urandom_range(0, 1)) << (nf + nef));
        w = nf + nef + 1;
        junk = {$urandom, $urandom};
        if (w < 64) x = x | (junk << w);
    endtask

    // Drives one operand from a negedge, scrambles the format inputs after capture, measures latency, then accepts.
    task automatic run_op(input logic [63:0] x, input int bias, input int nf, output res_t got, output int lat);
        int w;
        w = 0;
        while (!io.in_ready && w < 100) begin @(negedge clk); w++; end
        io.x = x; io.bias = 10'(bias); io.nf = 6'(nf); io.in_valid = 1'b1;
        @(negedge clk);
        io.in_valid = 1'b0;
        io.x = {$urandom, $urandom}; io.bias = 10'($urandom); io.nf = 6'($urandom);
        lat = 1;
        while (!io.out_valid && lat < 100) begin @(negedge clk); lat++; end
        if (!io.out_valid) lat = -1;
        got = cur_res();
        io.out_ready = 1'b1;
        @(negedge clk);
        io.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        res_t zr;
        zr = '0;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({io.in_ready, io.out_valid, cur_res()} !== {1'b1, 1'b0, zr}) begin
            n_fail++;
            $display("FAIL reset_state got rdy=%b vld=%b res=%h want rdy=1 vld=0 res=%h", io.in_ready, io.out_valid, cur_res(), zr);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        res_t got, want;
        int   lat;
        logic [63:0] xs [5] = '{64'h3F800000, 64'h00000001, 64'h7FF0000000000000, 64'h7FF8000000000000, 64'h8000000000000000};
        int          bs [5] = '{127, 127, 1023, 1023, 1023};
        int          ns [5] = '{23, 23, 52, 52, 52};
        int          ls [5] = '{1, 24, 1, 1, 1};
        res_t        ws [5];
        ws[0] = '{sgn: 1'b0, exp: 13'd0,          mant: 53'd1 << 52, flags: 4'b0000};
        ws[1] = '{sgn: 1'b0, exp: 13'(-149),      mant: 53'd1 << 52, flags: 4'b0001};
        ws[2] = '{sgn: 1'b0, exp: 13'd1024,       mant: 53'd1 << 52, flags: 4'b0100};
        ws[3] = '{sgn: 1'b0, exp: 13'd1024,       mant: 53'd3 << 51, flags: 4'b0010};
        ws[4] = '{sgn: 1'b1, exp: 13'd0,          mant: 53'd0,       flags: 4'b1000};
        for (int i = 0; i < 5; i++) begin
            run_op(xs[i], bs[i], ns[i], got, lat);
            want = ws[i];
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL directed_res[%0d] got=%h want=%h", i, got, want);
            end
            n_tests++;
            if (lat !== ls[i]) begin
                n_fail++;
                $display("FAIL directed_lat[%0d] got=%0d want=%0d", i, lat, ls[i]);
            end
        end
    endtask

    task automatic test_random();
        res_t        got, want;
        int          lat, wlat, bias, nf;
        logic [63:0] x;
        for (int i = 0; i < 60; i++) begin
            gen_op(x, bias, nf);
            want = model(x, bias, nf, wlat);
            run_op(x, bias, nf, got, lat);
            n_tests++;
            if (got !== want || lat !== wlat) begin
                n_fail++;
                $display("FAIL random[%0d] x=%h bias=%0d nf=%0d got=%h lat=%0d want=%h lat=%0d", i, x, bias, nf, got, lat, want, wlat);
            end
        end
    endtask

    task automatic test_backpressure();
        res_t snap, want;
        int   lat, nvld;
        want = model(64'h3F800000, 127, 23, lat);
        io.x = 64'h3F800000; io.bias = 10'd127; io.nf = 6'd23; io.in_valid = 1'b1;
        @(negedge clk);
        io.x = 64'h7FF0000000000000; io.bias = 10'd1023; io.nf = 6'd52;
        snap = cur_res();
        n_tests++;
        if (snap !== want || io.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_first got=%h vld=%b want=%h vld=1", snap, io.out_valid, want);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_tests++;
            if ({io.out_valid, io.in_ready, cur_res()} !== {1'b1, 1'b0, snap}) begin
                n_fail++;
                $display("FAIL bp_hold[%0d] got vld=%b rdy=%b res=%h want vld=1 rdy=0 res=%h", c, io.out_valid, io.in_ready, cur_res(), snap);
            end
        end
        io.out_ready = 1'b1;
        @(negedge clk);
        io.out_ready = 1'b0;
        io.in_valid = 1'b0;
        n_tests++;
        if ({io.out_valid, io.in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL bp_release got vld=%b rdy=%b want vld=0 rdy=1", io.out_valid, io.in_ready);
        end
        nvld = 0;
        repeat (4) begin @(negedge clk); if (io.out_valid) nvld++; end
        n_tests++;
        if (nvld !== 0) begin
            n_fail++;
            $display("FAIL bp_no_capture got %0d valid cycles want 0", nvld);
        end
    endtask

    task automatic test_flush();
        res_t got, want;
        int   lat, wlat;
        logic seen;
        seen = 1'b0;
        io.x = 64'h1; io.bias = 10'd127; io.nf = 6'd23; io.in_valid = 1'b1;
        @(negedge clk);
        io.in_valid = 1'b0;
        for (int c = 1; c < 10; c++) begin
            seen |= io.out_valid;
            @(negedge clk);
        end
        io.flush = 1'b1;
        io.in_valid = 1'b1; io.x = 64'h3F800000;
        @(negedge clk);
        io.flush = 1'b0; io.in_valid = 1'b0;
        n_tests++;
        if ({io.in_ready, io.out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL flush_idle got rdy=%b vld=%b want rdy=1 vld=0", io.in_ready, io.out_valid);
        end
        repeat (30) begin seen |= io.out_valid; @(negedge clk); end
        n_tests++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_killed got out_valid seen=%b want 0", seen);
        end
        want = model(64'hBFC00000, 127, 23, wlat);
        run_op(64'hBFC00000, 127, 23, got, lat);
        n_tests++;
        if (got !== want || lat !== wlat) begin
            n_fail++;
            $display("FAIL flush_next got=%h lat=%0d want=%h lat=%0d", got, lat, want, wlat);
        end
    endtask

    task automatic test_back_to_back();
        res_t        q[$];
        res_t        want, got;
        logic [63:0] x;
        int          bias, nf, lat, idx, ndone, cyc;
        idx = 0; ndone = 0; cyc = 0;
        io.out_ready = 1'b1;
        while (ndone < 16 && cyc < 3000) begin
            if (io.out_valid) begin
                got = cur_res();
                want = (q.size() > 0) ? q.pop_front() : '0;
                n_tests++;
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL b2b[%0d] got=%h want=%h", ndone, got, want);
                end
                ndone++;
            end
            if (io.in_ready) begin
                if (idx < 16) begin
                    gen_op(x, bias, nf);
                    q.push_back(model(x, bias, nf, lat));
                    io.x = x; io.bias = 10'(bias); io.nf = 6'(nf); io.in_valid = 1'b1;
                    idx++;
                end else begin
                    io.in_valid = 1'b0;
                end
            end
            @(negedge clk);
            cyc++;
        end
        io.in_valid = 1'b0;
        io.out_ready = 1'b0;
        n_tests++;
        if (ndone !== 16) begin
            n_fail++;
            $display("FAIL b2b_count got %0d results want 16", ndone);
        end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        res_t zr, got, want;
        int   lat, wlat;
        zr = '0;
        io.x = 64'h1; io.bias = 10'd127; io.nf = 6'd23; io.in_valid = 1'b1;
        @(negedge clk);
        io.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        n_tests++;
        if ({io.in_ready, io.out_valid, cur_res()} !== {1'b1, 1'b0, zr}) begin
            n_fail++;
            $display("FAIL async_reset got rdy=%b vld=%b res=%h want rdy=1 vld=0 res=%h", io.in_ready, io.out_valid, cur_res(), zr);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        want = model(64'h0000000000000003, 1023, 52, wlat);
        run_op(64'h0000000000000003, 1023, 52, got, lat);
        n_tests++;
        if (got !== want || lat !== wlat) begin
            n_fail++;
            $display("FAIL async_recover got=%h lat=%0d want=%h lat=%0d", got, lat, want, wlat);
        end
    endtask

    initial begin
        io.flush = 1'b0; io.in_valid = 1'b0; io.out_ready = 1'b0;
        io.x = '0; io.bias = '0; io.nf = '0;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_flush();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
